// File: rtl/uc_asm_mc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, instruction
// classes, opcodes, ULA operation codes and register-file write source codes.
package uc_asm_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_IALU   = 4'd1,
        CL_LOAD   = 4'd2,
        CL_STORE  = 4'd3,
        CL_BRANCH = 4'd4,
        CL_JAL    = 4'd5,
        CL_JALR   = 4'd6,
        CL_LUI    = 4'd7,
        CL_AUIPC  = 4'd8,
        CL_ILL    = 4'd9
    } class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ULA_ADD  = 4'd0;
    localparam logic [3:0] ULA_SUB  = 4'd1;
    localparam logic [3:0] ULA_SLL  = 4'd2;
    localparam logic [3:0] ULA_SLT  = 4'd3;
    localparam logic [3:0] ULA_SLTU = 4'd4;
    localparam logic [3:0] ULA_XOR  = 4'd5;
    localparam logic [3:0] ULA_SRL  = 4'd6;
    localparam logic [3:0] ULA_SRA  = 4'd7;
    localparam logic [3:0] ULA_OR   = 4'd8;
    localparam logic [3:0] ULA_AND  = 4'd9;

    localparam logic [1:0] RF_ALU = 2'b00;
    localparam logic [1:0] RF_MEM = 2'b01;
    localparam logic [1:0] RF_PC4 = 2'b10;
    localparam logic [1:0] RF_IMM = 2'b11;

    // Branches with funct3 010/011 have no RV32I meaning and are treated as illegal.
    function automatic class_t decode_class(input logic [6:0] opcode, input logic [2:0] funct3);
        class_t cl;
        case (opcode)
            OP_R:      cl = CL_R;
            OP_IALU:   cl = CL_IALU;
            OP_LOAD:   cl = CL_LOAD;
            OP_STORE:  cl = CL_STORE;
            OP_BRANCH: cl = (funct3[2:1] == 2'b01) ? CL_ILL : CL_BRANCH;
            OP_JAL:    cl = CL_JAL;
            OP_JALR:   cl = CL_JALR;
            OP_LUI:    cl = CL_LUI;
            OP_AUIPC:  cl = CL_AUIPC;
            default:   cl = CL_ILL;
        endcase
        return cl;
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt);
        logic taken;
        case (funct3)
            3'b000:          taken = zero;
            3'b001:          taken = ~zero;
            3'b100, 3'b110:  taken = lt;
            3'b101, 3'b111:  taken = ~lt;
            default:         taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/uc_asm_mc_ula_ctrl.sv
// Combinational ULA operation decode from the latched instruction class and
// the IR funct fields.
module uc_asm_mc_ula_ctrl
    import uc_asm_mc_pkg::*;
(
    input  class_t     i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_ula_op
);

    logic [3:0] w_alu_op;

    // Shared R / I-ALU table; only R uses funct7_5 to pick SUB over ADD.
    always_comb begin
        w_alu_op = ULA_ADD;
        case (i_funct3)
            3'b000: w_alu_op = (i_funct7_5 && i_class == CL_R) ? ULA_SUB : ULA_ADD;
            3'b001: w_alu_op = ULA_SLL;
            3'b010: w_alu_op = ULA_SLT;
            3'b011: w_alu_op = ULA_SLTU;
            3'b100: w_alu_op = ULA_XOR;
            3'b101: w_alu_op = i_funct7_5 ? ULA_SRA : ULA_SRL;
            3'b110: w_alu_op = ULA_OR;
            3'b111: w_alu_op = ULA_AND;
            default: w_alu_op = ULA_ADD;
        endcase
    end

    always_comb begin
        o_ula_op = ULA_ADD;
        case (i_class)
            CL_R, CL_IALU: o_ula_op = w_alu_op;
            CL_BRANCH: begin
                case (i_funct3[2:1])
                    2'b10:   o_ula_op = ULA_SLT;
                    2'b11:   o_ula_op = ULA_SLTU;
                    default: o_ula_op = ULA_SUB;
                endcase
            end
            default: o_ula_op = ULA_ADD;
        endcase
    end

endmodule

// File: rtl/uc_asm_mc.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// datapath selects, enables and memory requests from the IR fields.
//
// state  | meaning
// IDLE   | after reset, one cycle before the first fetch
// FETCH  | instruction read; IR loads when memory completes
// DECODE | instruction class latched from opcode
// EXEC   | ALU operand selection; branches resolve here
// MEM    | data access for LOAD / STORE
// WB     | register write and PC update
// TRAP   | illegal instruction, held until reset
module uc_asm_mc
    import uc_asm_mc_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int MEM_HS  = 0,
    parameter int CNT_W   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_ula_zero,
    input  logic       i_ula_lt,
    input  logic       i_mem_ready,
    output logic       o_we_rf,
    output logic       o_we_mem,
    output logic       o_re_mem,
    output logic [1:0] o_rf_din_sel,
    output logic       o_ula_din1_sel,
    output logic       o_ula_din2_sel,
    output logic [3:0] o_ula_op,
    output logic       o_load_pc,
    output logic       o_load_ir,
    output logic       o_pc_next_sel,
    output logic       o_pc_adder_sel,
    output logic       o_illegal
);

    state_t           r_state;
    class_t           r_class;
    logic [CNT_W-1:0] r_cnt;

    class_t           w_dec_class;
    logic             w_done;
    logic             w_taken;
    logic [3:0]       w_ula_op;

    assign w_dec_class = decode_class(i_opcode, i_funct3);
    assign w_taken     = branch_taken(i_funct3, i_ula_zero, i_ula_lt);
    assign w_done      = (MEM_HS != 0) ? i_mem_ready : (r_cnt == CNT_W'(MEM_LAT));

    uc_asm_mc_ula_ctrl u_ula_ctrl (
        .i_class    (r_class),
        .i_funct3   (i_funct3),
        .i_funct7_5 (i_funct7_5),
        .o_ula_op   (w_ula_op)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_class <= CL_R;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_DECODE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    r_cnt   <= '0;
                    r_class <= w_dec_class;
                    r_state <= (w_dec_class == CL_ILL) ? ST_TRAP : ST_EXEC;
                end
                ST_EXEC: begin
                    r_cnt <= '0;
                    case (r_class)
                        CL_LOAD, CL_STORE: r_state <= ST_MEM;
                        CL_BRANCH:         r_state <= ST_FETCH;
                        default:           r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= (r_class == CL_LOAD) ? ST_WB : ST_FETCH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WB: begin
                    r_cnt   <= '0;
                    r_state <= ST_FETCH;
                end
                ST_TRAP: begin
                    r_cnt   <= '0;
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state, so an async reset clears them at once.
    always_comb begin
        o_we_rf        = 1'b0;
        o_we_mem       = 1'b0;
        o_re_mem       = 1'b0;
        o_rf_din_sel   = RF_ALU;
        o_ula_din1_sel = 1'b0;
        o_ula_din2_sel = 1'b0;
        o_ula_op       = ULA_ADD;
        o_load_pc      = 1'b0;
        o_load_ir      = 1'b0;
        o_pc_next_sel  = 1'b0;
        o_pc_adder_sel = 1'b0;
        o_illegal      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_re_mem  = 1'b1;
                o_load_ir = w_done;
            end
            ST_EXEC: begin
                o_ula_op = w_ula_op;
                case (r_class)
                    CL_IALU, CL_LOAD, CL_STORE: o_ula_din2_sel = 1'b1;
                    CL_AUIPC: begin
                        o_ula_din1_sel = 1'b1;
                        o_ula_din2_sel = 1'b1;
                    end
                    CL_BRANCH: begin
                        o_load_pc     = 1'b1;
                        o_pc_next_sel = w_taken;
                    end
                    default: o_ula_din2_sel = 1'b0;
                endcase
            end
            ST_MEM: begin
                o_ula_op = w_ula_op;
                if (r_class == CL_STORE) begin
                    o_we_mem  = 1'b1;
                    o_load_pc = w_done;
                end else begin
                    o_re_mem = 1'b1;
                end
            end
            ST_WB: begin
                o_ula_op  = w_ula_op;
                o_we_rf   = 1'b1;
                o_load_pc = 1'b1;
                case (r_class)
                    CL_LOAD:          o_rf_din_sel = RF_MEM;
                    CL_JAL, CL_JALR:  o_rf_din_sel = RF_PC4;
                    CL_LUI:           o_rf_din_sel = RF_IMM;
                    default:          o_rf_din_sel = RF_ALU;
                endcase
                o_pc_next_sel  = (r_class == CL_JAL) || (r_class == CL_JALR);
                o_pc_adder_sel = (r_class == CL_JALR);
            end
            ST_TRAP: o_illegal = 1'b1;
            default: o_illegal = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uc_asm_mc.sv
// Directed scoreboard bench for uc_asm_mc: three instances (fixed latency 0,
// fixed latency 2, handshake) share stimulus; each step checks one instance.
module tb_uc_asm_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       ula_zero;
    logic       ula_lt;
    logic       mem_ready;

    logic       we_rf[3], we_mem[3], re_mem[3], d1[3], d2[3];
    logic [1:0] rf_sel[3];
    logic [3:0] ula_op[3];
    logic       load_pc[3], load_ir[3], pc_next[3], pc_adder[3], illegal[3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        logic        rdy;
        logic [15:0] exp;
        string       tag;
    } ent_t;

    ent_t sb[$];

    always #5 clk = ~clk;

    uc_asm_mc #(.MEM_LAT(0), .MEM_HS(0), .CNT_W(4)) dut0 (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct3(funct3),
        .i_funct7_5(funct7_5), .i_ula_zero(ula_zero), .i_ula_lt(ula_lt),
        .i_mem_ready(mem_ready), .o_we_rf(we_rf[0]), .o_we_mem(we_mem[0]),
        .o_re_mem(re_mem[0]), .o_rf_din_sel(rf_sel[0]), .o_ula_din1_sel(d1[0]),
        .o_ula_din2_sel(d2[0]), .o_ula_op(ula_op[0]), .o_load_pc(load_pc[0]),
        .o_load_ir(load_ir[0]), .o_pc_next_sel(pc_next[0]),
        .o_pc_adder_sel(pc_adder[0]), .o_illegal(illegal[0]));

    uc_asm_mc #(.MEM_LAT(2), .MEM_HS(0), .CNT_W(4)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct3(funct3),
        .i_funct7_5(funct7_5), .i_ula_zero(ula_zero), .i_ula_lt(ula_lt),
        .i_mem_ready(mem_ready), .o_we_rf(we_rf[1]), .o_we_mem(we_mem[1]),
        .o_re_mem(re_mem[1]), .o_rf_din_sel(rf_sel[1]), .o_ula_din1_sel(d1[1]),
        .o_ula_din2_sel(d2[1]), .o_ula_op(ula_op[1]), .o_load_pc(load_pc[1]),
        .o_load_ir(load_ir[1]), .o_pc_next_sel(pc_next[1]),
        .o_pc_adder_sel(pc_adder[1]), .o_illegal(illegal[1]));

    uc_asm_mc #(.MEM_LAT(1), .MEM_HS(1), .CNT_W(4)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct3(funct3),
        .i_funct7_5(funct7_5), .i_ula_zero(ula_zero), .i_ula_lt(ula_lt),
        .i_mem_ready(mem_ready), .o_we_rf(we_rf[2]), .o_we_mem(we_mem[2]),
        .o_re_mem(re_mem[2]), .o_rf_din_sel(rf_sel[2]), .o_ula_din1_sel(d1[2]),
        .o_ula_din2_sel(d2[2]), .o_ula_op(ula_op[2]), .o_load_pc(load_pc[2]),
        .o_load_ir(load_ir[2]), .o_pc_next_sel(pc_next[2]),
        .o_pc_adder_sel(pc_adder[2]), .o_illegal(illegal[2]));

    // {we_rf, we_mem, re_mem, rf_sel[1:0], din1, din2, ula_op[3:0], load_pc, load_ir, pc_next, pc_adder, illegal}
    function automatic logic [15:0] mk(input logic wrf, input logic wmem, input logic rmem,
                                       input logic [1:0] rfs, input logic a1, input logic a2,
                                       input logic [3:0] op, input logic lpc, input logic lir,
                                       input logic pns, input logic pas, input logic ill);
        return {wrf, wmem, rmem, rfs, a1, a2, op, lpc, lir, pns, pas, ill};
    endfunction

    function automatic logic [15:0] obs(input int d);
        return {we_rf[d], we_mem[d], re_mem[d], rf_sel[d], d1[d], d2[d], ula_op[d],
                load_pc[d], load_ir[d], pc_next[d], pc_adder[d], illegal[d]};
    endfunction

    task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input int d, input logic rdy, input logic [15:0] e, input string tag);
        ent_t x;
        x.dut = d;
        x.rdy = rdy;
        x.exp = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // Each entry is one clock cycle: apply ready, sample at negedge, move on.
    task automatic drain();
        ent_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            mem_ready = x.rdy;
            @(negedge clk);
            check(x.tag, obs(x.dut), x.exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #10;
        for (int d = 0; d < 3; d++) check("reset_outputs", obs(d), 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [15:0] e_idle, e_fetch, e_fstall, e_dec, e_trap;

    initial begin
        e_idle   = 16'h0000;
        e_fetch  = mk(0, 0, 1, 2'b00, 0, 0, 4'd0, 0, 1, 0, 0, 0);
        e_fstall = mk(0, 0, 1, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 0);
        e_dec    = 16'h0000;
        e_trap   = mk(0, 0, 0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 1);
        ula_zero = 1'b0;
        ula_lt   = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b1);
        do_reset();

        // R-type SUB, MEM_LAT=0
        push(0, 1, e_idle, "r_idle");
        push(0, 1, e_fetch, "r_fetch");
        push(0, 1, e_dec, "r_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 0, 0, 4'd1, 0, 0, 0, 0, 0), "r_exec");
        push(0, 1, mk(1, 0, 0, 2'b00, 0, 0, 4'd1, 1, 0, 0, 0, 0), "r_wb");
        push(0, 1, e_fetch, "r_fetch2");
        drain();

        set_instr(7'b0010011, 3'b101, 1'b1);  // SRAI
        push(0, 1, e_dec, "srai_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 0, 1, 4'd7, 0, 0, 0, 0, 0), "srai_exec");
        push(0, 1, mk(1, 0, 0, 2'b00, 0, 0, 4'd7, 1, 0, 0, 0, 0), "srai_wb");
        push(0, 1, e_fetch, "srai_fetch");
        drain();

        set_instr(7'b1100011, 3'b000, 1'b0);  // BEQ taken
        ula_zero = 1'b1;
        push(0, 1, e_dec, "beq_t_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 0, 0, 4'd1, 1, 0, 1, 0, 0), "beq_t_exec");
        push(0, 1, e_fetch, "beq_t_fetch");
        drain();

        ula_zero = 1'b0;                      // BEQ not taken
        push(0, 1, e_dec, "beq_n_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 0, 0, 4'd1, 1, 0, 0, 0, 0), "beq_n_exec");
        push(0, 1, e_fetch, "beq_n_fetch");
        drain();

        set_instr(7'b1100011, 3'b110, 1'b0);  // BLTU taken
        ula_lt = 1'b1;
        push(0, 1, e_dec, "bltu_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 0, 0, 4'd4, 1, 0, 1, 0, 0), "bltu_exec");
        push(0, 1, e_fetch, "bltu_fetch");
        drain();

        set_instr(7'b1100011, 3'b101, 1'b0);  // BGE with lt=1 -> not taken
        push(0, 1, e_dec, "bge_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 0, 0, 4'd3, 1, 0, 0, 0, 0), "bge_exec");
        push(0, 1, e_fetch, "bge_fetch");
        drain();
        ula_lt = 1'b0;

        set_instr(7'b1100111, 3'b000, 1'b0);  // JALR
        push(0, 1, e_dec, "jalr_decode");
        push(0, 1, 16'h0000, "jalr_exec");
        push(0, 1, mk(1, 0, 0, 2'b10, 0, 0, 4'd0, 1, 0, 1, 1, 0), "jalr_wb");
        push(0, 1, e_fetch, "jalr_fetch");
        drain();

        set_instr(7'b0110111, 3'b000, 1'b0);  // LUI
        push(0, 1, e_dec, "lui_decode");
        push(0, 1, 16'h0000, "lui_exec");
        push(0, 1, mk(1, 0, 0, 2'b11, 0, 0, 4'd0, 1, 0, 0, 0, 0), "lui_wb");
        push(0, 1, e_fetch, "lui_fetch");
        drain();

        set_instr(7'b0010111, 3'b000, 1'b0);  // AUIPC
        push(0, 1, e_dec, "auipc_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 1, 1, 4'd0, 0, 0, 0, 0, 0), "auipc_exec");
        push(0, 1, mk(1, 0, 0, 2'b00, 0, 0, 4'd0, 1, 0, 0, 0, 0), "auipc_wb");
        push(0, 1, e_fetch, "auipc_fetch");
        drain();

        set_instr(7'b0100011, 3'b010, 1'b0);  // STORE, single-cycle memory
        push(0, 1, e_dec, "sw0_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 0, 1, 4'd0, 0, 0, 0, 0, 0), "sw0_exec");
        push(0, 1, mk(0, 1, 0, 2'b00, 0, 0, 4'd0, 1, 0, 0, 0, 0), "sw0_mem");
        push(0, 1, e_fetch, "sw0_fetch");
        drain();

        set_instr(7'b0000011, 3'b010, 1'b0);  // LOAD, single-cycle memory
        push(0, 1, e_dec, "lw0_decode");
        push(0, 1, mk(0, 0, 0, 2'b00, 0, 1, 4'd0, 0, 0, 0, 0, 0), "lw0_exec");
        push(0, 1, e_fstall, "lw0_mem");
        push(0, 1, mk(1, 0, 0, 2'b01, 0, 0, 4'd0, 1, 0, 0, 0, 0), "lw0_wb");
        push(0, 1, e_fetch, "lw0_fetch");
        drain();

        set_instr(7'b1100011, 3'b010, 1'b0);  // reserved branch funct3
        push(0, 1, e_dec, "brill_decode");
        push(0, 1, e_trap, "brill_trap");
        push(0, 1, e_trap, "brill_trap_hold");
        drain();

        set_instr(7'b1111111, 3'b000, 1'b0);  // unknown opcode
        do_reset();
        push(0, 1, e_idle, "ill_idle");
        push(0, 1, e_fetch, "ill_fetch");
        push(0, 1, e_dec, "ill_decode");
        for (int i = 0; i < 3; i++) push(0, 1, e_trap, "ill_trap");
        drain();

        // LOAD with MEM_LAT=2: three RE_MEM cycles in FETCH and in MEM
        set_instr(7'b0000011, 3'b010, 1'b0);
        do_reset();
        push(1, 1, e_idle, "lw2_idle");
        push(1, 1, e_fstall, "lw2_fetch_w0");
        push(1, 1, e_fstall, "lw2_fetch_w1");
        push(1, 1, e_fetch, "lw2_fetch_done");
        push(1, 1, e_dec, "lw2_decode");
        push(1, 1, mk(0, 0, 0, 2'b00, 0, 1, 4'd0, 0, 0, 0, 0, 0), "lw2_exec");
        for (int i = 0; i < 3; i++) push(1, 1, e_fstall, "lw2_mem");
        push(1, 1, mk(1, 0, 0, 2'b01, 0, 0, 4'd0, 1, 0, 0, 0, 0), "lw2_wb");
        push(1, 1, e_fstall, "lw2_fetch_next");
        drain();

        // STORE with handshake: ready low 5 cycles in MEM
        set_instr(7'b0100011, 3'b010, 1'b0);
        do_reset();
        push(2, 1, e_idle, "swhs_idle");
        push(2, 1, e_fetch, "swhs_fetch");
        push(2, 1, e_dec, "swhs_decode");
        push(2, 1, mk(0, 0, 0, 2'b00, 0, 1, 4'd0, 0, 0, 0, 0, 0), "swhs_exec");
        for (int i = 0; i < 5; i++)
            push(2, 0, mk(0, 1, 0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 0), "swhs_mem_wait");
        push(2, 1, mk(0, 1, 0, 2'b00, 0, 0, 4'd0, 1, 0, 0, 0, 0), "swhs_mem_done");
        push(2, 0, e_fstall, "swhs_fetch_stall");
        push(2, 1, e_fetch, "swhs_fetch_done");
        push(2, 1, e_dec, "swhs2_decode");
        push(2, 1, mk(0, 0, 0, 2'b00, 0, 1, 4'd0, 0, 0, 0, 0, 0), "swhs2_exec");
        push(2, 0, mk(0, 1, 0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 0), "swhs2_mem_wait");
        push(2, 0, mk(0, 1, 0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 0), "swhs2_mem_wait");
        drain();

        // Still in MEM with ready low: reset must drop WE_MEM immediately
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mid_store", obs(2), 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(2, 1, e_idle, "post_rst_idle");
        push(2, 1, e_fetch, "post_rst_fetch");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
